// File: rtl/adc_apb_pkg.sv
// Register map, status bit positions, result error codes and sequence states
// shared by the ADC APB conversion sequencer and its transfer engine.
package adc_apb_pkg;

  localparam logic [11:0] REG_STATUS = 12'h000;
  localparam logic [11:0] REG_MEAS   = 12'h004;
  localparam logic [11:0] REG_PLL    = 12'h008;
  localparam logic [11:0] REG_AMUX   = 12'h00C;
  localparam logic [11:0] REG_TRIG   = 12'h010;

  localparam int STATUS_DONE_BIT = 0;
  localparam int STATUS_BUSY_BIT = 1;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_SLV     = 2'b01,
    ERR_TIMEOUT = 2'b10
  } res_err_e;

  typedef enum logic [2:0] {
    S_IDLE, S_AMUX, S_TRIG, S_POLL, S_GAP, S_MEAS, S_RESP
  } seq_state_e;

endpackage

// File: rtl/apb_master_port.sv
// Single APB transfer engine: req starts SETUP next cycle, ACCESS held until PREADY.
// done is combinational in the completing cycle; a req in that cycle chains the next SETUP.
module apb_master_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;

  assign done  = psel_q & penable_q & PREADY;
  assign rdata = PRDATA;
  assign err   = PSLVERR;

  always_comb begin
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    if (req) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = req_write;
      paddr_d   = req_addr;
      pwdata_d  = req_wdata;
    end else if (done) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
    end else if (psel_q) begin
      penable_d = 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: rtl/adc_apb_sequencer.sv
// Runs AMUX write, trigger, status polling and measurement read per command; result
// held until res_ready, new commands taken only when idle with no pending result.
module adc_apb_sequencer
  import adc_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_POLLS  = 16,
  parameter int POLL_GAP   = 4
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_channel,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [3:0]            res_channel,
  output logic [1:0]            res_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int PCW = $clog2(MAX_POLLS + 1);
  localparam int GCW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

  seq_state_e            state_q, state_d;
  logic [PCW-1:0]        poll_cnt_q, poll_cnt_d, poll_inc;
  logic [GCW-1:0]        gap_cnt_q, gap_cnt_d;
  logic [3:0]            chan_q, chan_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  res_err_e              res_err_q, res_err_d;

  logic                  req, req_write, xfer_done, xfer_err;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata, xfer_rdata;

  assign poll_inc = poll_cnt_q + PCW'(1);

  always_comb begin
    state_d     = state_q;
    poll_cnt_d  = poll_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    chan_d      = chan_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    req         = 1'b0;
    req_addr    = ADDR_WIDTH'(REG_STATUS);
    req_write   = 1'b0;
    req_wdata   = '0;
    // A slave error on any completing transfer abandons the rest of the sequence.
    if (xfer_done && xfer_err) begin
      state_d     = S_RESP;
      res_valid_d = 1'b1;
      res_data_d  = '0;
      res_err_d   = ERR_SLV;
    end else begin
      case (state_q)
        S_IDLE: if (cmd_valid && cmd_ready_q) begin
          state_d    = S_AMUX;
          chan_d     = cmd_channel;
          poll_cnt_d = '0;
          req        = 1'b1;
          req_addr   = ADDR_WIDTH'(REG_AMUX);
          req_write  = 1'b1;
          req_wdata  = DATA_WIDTH'(cmd_channel);
        end
        S_AMUX: if (xfer_done) begin
          state_d   = S_TRIG;
          req       = 1'b1;
          req_addr  = ADDR_WIDTH'(REG_TRIG);
          req_write = 1'b1;
          req_wdata = DATA_WIDTH'(1);
        end
        S_TRIG: if (xfer_done) begin
          state_d = S_POLL;
          req     = 1'b1;
        end
        S_POLL: if (xfer_done) begin
          poll_cnt_d = poll_inc;
          if (xfer_rdata[STATUS_DONE_BIT]) begin
            state_d  = S_MEAS;
            req      = 1'b1;
            req_addr = ADDR_WIDTH'(REG_MEAS);
          end else if (poll_inc == PCW'(MAX_POLLS)) begin
            state_d     = S_RESP;
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_err_d   = ERR_TIMEOUT;
          end else if (POLL_GAP == 0) begin
            req = 1'b1;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = GCW'(POLL_GAP - 1);
          end
        end
        S_GAP: begin
          if (gap_cnt_q == '0) begin
            state_d = S_POLL;
            req     = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q - GCW'(1);
          end
        end
        S_MEAS: if (xfer_done) begin
          state_d     = S_RESP;
          res_valid_d = 1'b1;
          res_data_d  = xfer_rdata;
          res_err_d   = ERR_OK;
        end
        S_RESP: if (res_ready) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
    cmd_ready_d = (state_d == S_IDLE) && !res_valid_d;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      poll_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      chan_q      <= '0;
      cmd_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= ERR_OK;
    end else begin
      state_q     <= state_d;
      poll_cnt_q  <= poll_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      chan_q      <= chan_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  apb_master_port #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_port (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req(req), .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .done(xfer_done), .rdata(xfer_rdata), .err(xfer_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  assign cmd_ready   = cmd_ready_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_channel = chan_q;
  assign res_err     = res_err_q;

endmodule

// File: tb/tb_adc_apb_sequencer.sv
// Directed bench: behavioural APB ADC completer, one task per scenario.
module tb_adc_apb_sequencer;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, res_valid, res_ready = 1'b0;
  logic [3:0]  cmd_channel = 4'd0, res_channel;
  logic [31:0] res_data, PWDATA, PRDATA;
  logic [1:0]  res_err;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [11:0] PADDR;

  typedef struct {
    logic [11:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          setup;
  } xfer_t;

  xfer_t       log_q[$];
  xfer_t       cur;
  int          cyc = 0;
  int          tests_run = 0, tests_failed = 0;
  int          done_at = 1, wait_n = 0, wait_left = 0, status_reads = 0, stab_err = 0, psel_low = 0;
  logic [11:0] wait_addr = 12'hFFF, err_addr = 12'hFFF;
  logic        err_en = 1'b0;
  logic [31:0] meas_val = 32'h0;

  adc_apb_sequencer dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_channel(cmd_channel),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_channel(res_channel), .res_err(res_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial forever #5 PCLK = ~PCLK;
  initial forever begin @(posedge PCLK); cyc++; end

  // APB completer: responds on the falling edge, logs every completed transfer
  initial begin
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn || !PSEL) begin
        if (PRESETn) psel_low++;
        PREADY = 1'b0; PSLVERR = 1'b0;
      end else if (!PENABLE) begin
        cur = '{PADDR, PWRITE, PWDATA, cyc};
        wait_left = (PADDR == wait_addr) ? wait_n : 0;
        PREADY = 1'b0; PSLVERR = 1'b0;
      end else begin
        if (PADDR !== cur.addr || PWRITE !== cur.wr || PWDATA !== cur.wdata) stab_err++;
        if (wait_left > 0) begin
          wait_left--;
          PREADY = 1'b0;
        end else begin
          PREADY  = 1'b1;
          PSLVERR = err_en && (PADDR == err_addr);
          if (!PWRITE && PADDR == 12'h000) begin
            status_reads++;
            PRDATA = (done_at != 0 && status_reads >= done_at) ? 32'h1 : 32'h2;
          end else if (!PWRITE && PADDR == 12'h004) PRDATA = meas_val;
          else PRDATA = '0;
          log_q.push_back(cur);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic setup_slave(input int d_at, input logic [31:0] mv);
    done_at = d_at; meas_val = mv; status_reads = 0; stab_err = 0;
    log_q.delete();
  endtask

  task automatic send_cmd(input logic [3:0] ch, output int c0);
    int n;
    n = 0;
    cmd_channel = ch; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge PCLK); n++; end
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL send_cmd: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    @(negedge PCLK);
    c0 = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input int c0, input int bound, output int rel);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < bound) begin @(negedge PCLK); n++; end
    tests_run++;
    if (res_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL wait_res: res_valid=%b after %0d cycles, required 1", res_valid, n);
    end
    rel = cyc - c0 + 1;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(negedge PCLK);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    tests_run++;
    if ({PSEL, PENABLE, PWRITE, cmd_ready, res_valid} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: psel/pen/pwr/cmd_rdy/res_vld=%b required 00000",
               {PSEL, PENABLE, PWRITE, cmd_ready, res_valid});
    end
    tests_run++;
    if (PADDR !== 12'h0 || PWDATA !== 32'h0 || res_data !== 32'h0 || res_channel !== 4'h0 || res_err !== 2'b0) begin
      tests_failed++;
      $display("FAIL reset_data: paddr=%h pwdata=%h res_data=%h ch=%h err=%b required all 0",
               PADDR, PWDATA, res_data, res_channel, res_err);
    end
    PRESETn = 1'b1;
    @(negedge PCLK);
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_basic();
    logic [11:0] ea[4] = '{12'h00C, 12'h010, 12'h000, 12'h004};
    logic        ew[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] ed[4] = '{32'h5, 32'h1, 32'h0, 32'h0};
    int          er[4] = '{1, 3, 5, 7};
    int c0, rel;
    setup_slave(1, 32'h0000_0ABC);
    send_cmd(4'd5, c0);
    wait_res(c0, 100, rel);
    tests_run++;
    if (rel !== 9 || res_data !== 32'hABC || res_channel !== 4'd5 || res_err !== 2'b00) begin
      tests_failed++;
      $display("FAIL basic_result: cycle=%0d data=%h ch=%0d err=%b required 9 abc 5 00",
               rel, res_data, res_channel, res_err);
    end
    tests_run++;
    if (log_q.size() != 4) begin
      tests_failed++;
      $display("FAIL basic_count: %0d transfers required 4", log_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= log_q.size()) begin
        tests_failed++;
        $display("FAIL basic_xfer%0d: missing, required addr %h", i, ea[i]);
      end else if (log_q[i].addr !== ea[i] || log_q[i].wr !== ew[i] ||
                   (ew[i] && log_q[i].wdata !== ed[i]) || log_q[i].setup - c0 + 1 != er[i]) begin
        tests_failed++;
        $display("FAIL basic_xfer%0d: addr=%h wr=%b wdata=%h setup=%0d required %h %b %h %0d", i,
                 log_q[i].addr, log_q[i].wr, log_q[i].wdata, log_q[i].setup - c0 + 1, ea[i], ew[i], ed[i], er[i]);
      end
    end
    consume();
    tests_run++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_handshake: res_valid=%b cmd_ready=%b required 0 1", res_valid, cmd_ready);
    end
  endtask

  task automatic test_slverr_wait();
    int c0, rel;
    setup_slave(1, 32'hDEAD_BEEF);
    wait_addr = 12'h00C; wait_n = 3; err_en = 1'b1; err_addr = 12'h010;
    send_cmd(4'd9, c0);
    wait_res(c0, 100, rel);
    tests_run++;
    if (rel !== 8 || res_err !== 2'b01 || res_data !== 32'h0 || res_channel !== 4'd9) begin
      tests_failed++;
      $display("FAIL slverr_result: cycle=%0d err=%b data=%h ch=%0d required 8 01 0 9",
               rel, res_err, res_data, res_channel);
    end
    tests_run++;
    if (log_q.size() != 2 || status_reads != 0) begin
      tests_failed++;
      $display("FAIL slverr_abort: transfers=%0d status_reads=%0d required 2 0", log_q.size(), status_reads);
    end
    tests_run++;
    if (log_q.size() < 2 || log_q[1].setup - c0 + 1 != 6 || stab_err != 0) begin
      tests_failed++;
      $display("FAIL wait_extend: trig_setup=%0d unstable=%0d required 6 0",
               (log_q.size() < 2) ? -1 : log_q[1].setup - c0 + 1, stab_err);
    end
    wait_addr = 12'hFFF; wait_n = 0; err_en = 1'b0;
    consume();
  endtask

  task automatic test_poll_gap();
    int c0, rel, p0, k;
    int exp_setup[3] = '{5, 11, 17};
    setup_slave(3, 32'h0000_0123);
    send_cmd(4'd2, c0);
    p0 = psel_low;
    wait_res(c0, 200, rel);
    #1;
    tests_run++;
    if (rel !== 21 || res_data !== 32'h123 || res_err !== 2'b00 || res_channel !== 4'd2) begin
      tests_failed++;
      $display("FAIL gap_result: cycle=%0d data=%h err=%b ch=%0d required 21 123 00 2",
               rel, res_data, res_err, res_channel);
    end
    tests_run++;
    if (psel_low - p0 != 9) begin
      tests_failed++;
      $display("FAIL gap_psel_low: %0d idle cycles required 9", psel_low - p0);
    end
    k = 0;
    for (int i = 0; i < log_q.size(); i++)
      if (log_q[i].addr == 12'h000) begin
        tests_run++;
        if (k > 2 || log_q[i].setup - c0 + 1 != exp_setup[k]) begin
          tests_failed++;
          $display("FAIL gap_poll%0d: setup cycle=%0d required %0d", k, log_q[i].setup - c0 + 1,
                   (k > 2) ? -1 : exp_setup[k]);
        end
        k++;
      end
    tests_run++;
    if (k != 3 || log_q.size() != 6) begin
      tests_failed++;
      $display("FAIL gap_count: polls=%0d transfers=%0d required 3 6", k, log_q.size());
    end
    consume();
  endtask

  task automatic test_timeout();
    int c0, rel, n_stat, n_meas;
    setup_slave(0, 32'h0000_0FFF);
    send_cmd(4'd7, c0);
    wait_res(c0, 300, rel);
    n_stat = 0; n_meas = 0;
    foreach (log_q[i]) begin
      if (log_q[i].addr == 12'h000 && !log_q[i].wr) n_stat++;
      if (log_q[i].addr == 12'h004) n_meas++;
    end
    tests_run++;
    if (n_stat != 16 || n_meas != 0 || log_q.size() != 18) begin
      tests_failed++;
      $display("FAIL timeout_reads: status=%0d meas=%0d total=%0d required 16 0 18", n_stat, n_meas, log_q.size());
    end
    tests_run++;
    if (rel !== 97 || res_err !== 2'b10 || res_data !== 32'h0 || res_channel !== 4'd7) begin
      tests_failed++;
      $display("FAIL timeout_result: cycle=%0d err=%b data=%h ch=%0d required 97 10 0 7",
               rel, res_err, res_data, res_channel);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int c0, rel, bad;
    setup_slave(1, 32'h0000_55AA);
    send_cmd(4'd3, c0);
    cmd_channel = 4'd4; cmd_valid = 1'b1;
    wait_res(c0, 100, rel);
    bad = 0;
    repeat (10) begin
      if (res_valid !== 1'b1 || res_data !== 32'h55AA || res_channel !== 4'd3 ||
          res_err !== 2'b00 || cmd_ready !== 1'b0) bad++;
      @(negedge PCLK);
    end
    tests_run++;
    if (bad != 0 || log_q.size() != 4) begin
      tests_failed++;
      $display("FAIL stall_hold: unstable cycles=%0d transfers=%0d required 0 4", bad, log_q.size());
    end
    consume();
    tests_run++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || PSEL !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle: res_valid=%b cmd_ready=%b psel=%b required 0 1 0", res_valid, cmd_ready, PSEL);
    end
    @(negedge PCLK);
    c0 = cyc;
    cmd_valid = 1'b0;
    tests_run++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 12'h00C || PWDATA !== 32'h4 || cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_accept: psel=%b pen=%b paddr=%h pwdata=%h cmd_ready=%b required 1 0 00c 4 0",
               PSEL, PENABLE, PADDR, PWDATA, cmd_ready);
    end
    wait_res(c0, 100, rel);
    tests_run++;
    if (rel !== 9 || res_channel !== 4'd4 || res_data !== 32'h55AA) begin
      tests_failed++;
      $display("FAIL b2b_result: cycle=%0d ch=%0d data=%h required 9 4 55aa", rel, res_channel, res_data);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int c0, rel, n;
    setup_slave(0, 32'h0);
    send_cmd(4'd6, c0);
    n = 0;
    while (!(PSEL === 1'b1 && PENABLE === 1'b1 && PADDR === 12'h000) && n < 50) begin
      @(negedge PCLK); n++;
    end
    tests_run++;
    if (!(PSEL === 1'b1 && PENABLE === 1'b1 && PADDR === 12'h000)) begin
      tests_failed++;
      $display("FAIL rst_find_poll: no STATUS access after %0d cycles, required one", n);
    end
    PRESETn = 1'b0;
    #1;
    tests_run++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async: psel=%b penable=%b required 0 0", PSEL, PENABLE);
    end
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (3) @(negedge PCLK);
    tests_run++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || PSEL !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_discard: res_valid=%b cmd_ready=%b psel=%b required 0 1 0", res_valid, cmd_ready, PSEL);
    end
    setup_slave(1, 32'h0000_0077);
    send_cmd(4'd10, c0);
    wait_res(c0, 100, rel);
    tests_run++;
    if (log_q.size() != 4 || log_q[0].addr !== 12'h00C || log_q[0].wdata !== 32'hA) begin
      tests_failed++;
      $display("FAIL rst_rerun_seq: transfers=%0d first_addr=%h first_wdata=%h required 4 00c a",
               log_q.size(), (log_q.size() > 0) ? log_q[0].addr : 12'hFFF,
               (log_q.size() > 0) ? log_q[0].wdata : 32'hFFFF_FFFF);
    end
    tests_run++;
    if (rel !== 9 || res_data !== 32'h77 || res_channel !== 4'd10 || res_err !== 2'b00) begin
      tests_failed++;
      $display("FAIL rst_rerun_result: cycle=%0d data=%h ch=%0d err=%b required 9 77 10 00",
               rel, res_data, res_channel, res_err);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_slverr_wait();
    test_poll_gap();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
